// File: rtl/rgb_pl9823_chain_if.sv
// rgb_pl9823_chain_if
//   Bus between the colour-writing register logic and the PL9823 chain driver.
//   Signals:
//     wr_en      colour buffer write strobe
//     wr_addr    LED index (0 = first LED on the chain)
//     wr_rgb     colour word {R[23:16], G[15:8], B[7:0]}
//     start      frame request (level, sampled only while the driver is idle)
//     busy       frame in progress, latch gap included
//     frame_done one-cycle pulse in the first idle cycle after a frame
//     dout       registered serial data to the LED chain
//   Modports: master = register/bus side, slave = driver side.
interface rgb_pl9823_chain_if #(
  parameter int ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_rgb;
  logic              start;
  logic              busy;
  logic              frame_done;
  logic              dout;

  modport master (
    output wr_en, wr_addr, wr_rgb, start,
    input  busy, frame_done, dout
  );

  modport slave (
    input  wr_en, wr_addr, wr_rgb, start,
    output busy, frame_done, dout
  );
endinterface

// File: rtl/rgb_pl9823_chain.sv
// rgb_pl9823_chain
//   Serial driver for a daisy chain of N_LEDS PL9823 RGB LEDs. Colours are held
//   in an addressable N_LEDS x 24 buffer and sent on demand, MSB first, R/G/B,
//   LED 0 first. Each bit is a high pulse (T_LONG for a one, T_SHORT for a zero)
//   followed by a low phase that pads the bit to T_SHORT+T_LONG cycles. A frame
//   ends with T_RESET low cycles (latch gap).
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high; clears FSM, outputs and colour buffer
//     bus    rgb_pl9823_chain_if.slave (wr_en/wr_addr/wr_rgb, start, busy,
//            frame_done, dout)
//   Build option:
//     RGB_PL9823_AUTO_REFRESH_EN  when defined, the idle FSM behaves as if start
//     were always high, so frames repeat back to back and start is ignored.
module rgb_pl9823_chain #(
  parameter int N_LEDS  = 3,
  parameter int ADDR_W  = 8,
  parameter int T_SHORT = 18,
  parameter int T_LONG  = 68,
  parameter int T_RESET = 2500
) (
  input  logic              clk,
  input  logic              reset,
  rgb_pl9823_chain_if.slave bus
);

  localparam int T_BIT = T_SHORT + T_LONG;
  localparam int T_MAX = (T_RESET > T_BIT) ? T_RESET : T_BIT;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int LED_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // Counters hold the terminal count (duration - 1) and run down to zero.
  function automatic logic [CNT_W-1:0] high_last(input logic b);
    return b ? CNT_W'(T_LONG - 1) : CNT_W'(T_SHORT - 1);
  endfunction

  // Low phase pads the bit to T_SHORT+T_LONG, so it is the opposite length.
  function automatic logic [CNT_W-1:0] low_last(input logic b);
    return b ? CNT_W'(T_SHORT - 1) : CNT_W'(T_LONG - 1);
  endfunction

  logic [23:0]      buffer [N_LEDS];
  logic [1:0]       state;
  logic [CNT_W-1:0] t_cnt;
  logic [4:0]       bit_cnt;
  logic [LED_W-1:0] led_idx;
  logic [23:0]      shreg;
  logic             dout_r;
  logic             busy_r;
  logic             done_r;
  logic             go;
  logic [23:0]      next_word;

`ifdef RGB_PL9823_AUTO_REFRESH_EN
  // OR-ing start keeps the port referenced while forcing a permanent request.
  assign go = 1'b1 | bus.start;
`else
  assign go = bus.start;
`endif

  // Word for the following LED; read at the load edge, so a same-cycle write
  // to that LED is not seen until the next frame.
  assign next_word = buffer[led_idx + 1'b1];

  assign bus.dout       = dout_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = done_r;

  // Colour buffer: writes accepted in every state, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_LEDS; i++) buffer[i] <= '0;
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(N_LEDS))) begin
      buffer[bus.wr_addr[LED_W-1:0]] <= bus.wr_rgb;
    end
  end

  // Frame FSM; dout/busy/frame_done are registered alongside the state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      t_cnt   <= '0;
      bit_cnt <= '0;
      led_idx <= '0;
      shreg   <= '0;
      dout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            shreg   <= buffer[0];
            t_cnt   <= high_last(buffer[0][23]);
            bit_cnt <= 5'd23;
            led_idx <= '0;
            state   <= S_HIGH;
            dout_r  <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (t_cnt == '0) begin
            t_cnt  <= low_last(shreg[23]);
            state  <= S_LOW;
            dout_r <= 1'b0;
          end else begin
            t_cnt <= t_cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (t_cnt == '0) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              shreg   <= {shreg[22:0], 1'b0};
              t_cnt   <= high_last(shreg[22]);
              state   <= S_HIGH;
              dout_r  <= 1'b1;
            end else if (led_idx != LED_W'(N_LEDS - 1)) begin
              led_idx <= led_idx + 1'b1;
              shreg   <= next_word;
              t_cnt   <= high_last(next_word[23]);
              bit_cnt <= 5'd23;
              state   <= S_HIGH;
              dout_r  <= 1'b1;
            end else begin
              t_cnt <= CNT_W'(T_RESET - 1);
              state <= S_GAP;
            end
          end else begin
            t_cnt <= t_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (t_cnt == '0) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            t_cnt <= t_cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          dout_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
